stream_buffer_flushable: RTL and testbench
==========================================

# stream_buffer_flushable

Flushable valid/ready FIFO that sits directly downstream of the flushable stream arbiter. It takes the arbiter's single output stream and decouples it from the consumer, so a stalled consumer does not hold the arbitration tree locked. A shared `flush_i` discards all buffered beats in the same cycle that it flushes the arbiter.

## Interface
- `DATA_WIDTH`, default 1: payload width in bits.
- `DEPTH`, default 4: number of entries. Legal range is DEPTH ≥ 1; any other value is a fatal elaboration error. DEPTH need not be a power of two.
- Derived `PTR_W` = (DEPTH>1) ? $clog2(DEPTH) : 1.
- Derived `CNT_W` = $clog2(DEPTH+1).

Ports:
- `clk_i`, in, 1: clock. All state updates on the rising edge.
- `rst_ni`, in, 1: reset. Asynchronous, active-low.
- `flush_i`, in, 1: synchronous flush. Discards all entries.
- `inp_data_i`, in, DATA_WIDTH: input payload, connected to the arbiter's `oup_data_o`.
- `inp_valid_i`, in, 1: input valid.
- `inp_ready_o`, out, 1: input ready.
- `oup_data_o`, out, DATA_WIDTH: head-of-queue payload.
- `oup_valid_o`, out, 1: output valid.
- `oup_ready_i`, in, 1: output ready.
- `usage_o`, out, CNT_W: number of stored entries, 0..DEPTH.
- `full_o`, out, 1: usage_o == DEPTH.
- `empty_o`, out, 1: usage_o == 0.

## Operation
- **Storage:** DEPTH × DATA_WIDTH register array, plus write pointer `wr_ptr`, read pointer `rd_ptr` and counter `cnt`.
- **Pointer wrap:** each pointer wraps from DEPTH-1 to 0 by explicit compare, not by natural overflow. This is required for non-power-of-two DEPTH.
- **Output ports:**
  - inp_ready_o = !full_o && !flush_i.
  - oup_valid_o = !empty_o && !flush_i.
  - oup_data_o = mem[rd_ptr] when not empty; don't-care when empty (mem[rd_ptr] is acceptable).
- **Handshakes:**
  - push = inp_valid_i && inp_ready_o.
  - pop = oup_valid_o && oup_ready_i.
  - Both are therefore impossible during a flush.
- **On push:** mem[wr_ptr] <= inp_data_i, then wr_ptr advances.
- **On pop:** rd_ptr advances.
- **Counter:** cnt += push - pop. Simultaneous push and pop leaves cnt unchanged.
- **Flush:** next edge sets wr_ptr = rd_ptr = cnt = 0. Memory contents are not cleared.
- **Reset:** the asynchronous assertion sets the pointers and cnt to 0; memory is not reset.
  - Output values while rst_ni is low: inp_ready_o=1 (unless flush_i), oup_valid_o=0, usage_o=0, empty_o=1, full_o=0.
- **Full:** inp_ready_o is low even if oup_ready_i is high. There is no same-cycle pass-through, so ready never depends combinationally on oup_ready_i. This keeps the arbiter's gnt path short.
- **Empty:** there is no bypass; the first beat appears at the output one cycle after it is pushed.
- **Protocol guarantees:**
  - Once oup_valid_o is high with oup_ready_i low, oup_valid_o and oup_data_o hold until pop or flush.
  - Output valid never depends combinationally on oup_ready_i.
- **Assertions (simulation only):**
  - cnt ≤ DEPTH.
  - The output stability rule above, excluding flush cycles.
  - No push while full.

## Timing
- Latency from input handshake to oup_valid_o: 1 cycle.
- Throughput: 1 beat/cycle sustained when 0 < cnt < DEPTH and both sides are ready. At cnt == DEPTH with the consumer ready, the pattern is push-blocked for one cycle, then one push per pop.
- Flush effect: outputs are masked in the flush cycle itself. Empty state is visible on the cycle after the flush edge.
- DEPTH=1: alternates fill/drain, giving 1 beat per 2 cycles maximum.

## Test plan
- **Reset then single beat:** release reset, push 0x1 in cycle 0 → oup_valid_o=1 with data 0x1 in cycle 1, usage_o=1; pop in cycle 1 → empty_o=1 in cycle 2.
- **Fill to full:** DEPTH=4, oup_ready_i=0, push 0xA,0xB,0xC,0xD → full_o=1, inp_ready_o=0, and a fifth valid is not accepted. Then oup_ready_i=1 → output 0xA,0xB,0xC,0xD in order, with a push of 0xE accepted in the cycle after the first pop.
- **Simultaneous push/pop at cnt=2:** streaming for 10 cycles → usage_o stays 2 and data stays in order.
- **Wrap-around with DEPTH=3:** push and pop 7 beats 0..6 interleaved → output order 0..6 with no loss or duplication across the pointer wrap 2→0.
- **Flush mid-operation:** cnt=3 and inp_valid_i=1 with flush_i=1 for one cycle → inp_ready_o=0 and oup_valid_o=0 that cycle, no push or pop, and usage_o=0 the next cycle. A subsequent push of 0x5 emerges as the first output.
- **Async reset while full:** drop rst_ni mid-cycle → oup_valid_o=0 and usage_o=0 immediately without waiting for a clock; after release, normal operation resumes from empty.

Source files
------------

// File: rtl/stream_buffer_flushable.sv
// Flushable valid/ready FIFO decoupling the arbiter output from a stalling consumer.
// Registered-only ready/valid paths: no bypass when empty, no pass-through when full.
module stream_buffer_flushable #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int          DEPTH      = 4,
    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] inp_data_i,
    input  logic                  inp_valid_i,
    output logic                  inp_ready_o,
    output logic [DATA_WIDTH-1:0] oup_data_o,
    output logic                  oup_valid_o,
    input  logic                  oup_ready_i,
    output logic [CNT_W-1:0]      usage_o,
    output logic                  full_o,
    output logic                  empty_o
);

    if (DEPTH < 1) begin : g_bad_depth
        $fatal(1, "stream_buffer_flushable: DEPTH must be >= 1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  push, pop;

    // Explicit wrap so non-power-of-two depths index only valid entries.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o      = (cnt == CNT_W'(DEPTH));
    assign empty_o     = (cnt == '0);
    assign usage_o     = cnt;
    assign inp_ready_o = !full_o && !flush_i;
    assign oup_valid_o = !empty_o && !flush_i;
    assign oup_data_o  = mem[rd_ptr];

    assign push = inp_valid_i && inp_ready_o;
    assign pop  = oup_valid_o && oup_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= inp_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_cnt_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt <= CNT_W'(DEPTH));
    a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (oup_valid_o && !oup_ready_i) |=> (flush_i || (oup_valid_o && $stable(oup_data_o))));
    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full_o));
`endif

endmodule

// File: tb/tb_stream_buffer_flushable.sv
// Bench for stream_buffer_flushable: directed vector table, corner sequences,
// and randomized traffic against a queue model on DEPTH=4 and DEPTH=3 instances.
module tb_stream_buffer_flushable;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          a_flush, a_v, a_r, a_rdy, a_ov, a_full, a_empty;
    logic [DW-1:0] a_d, a_od;
    logic [2:0]    a_use;
    logic          b_flush, b_v, b_r, b_rdy, b_ov, b_full, b_empty;
    logic [DW-1:0] b_d, b_od;
    logic [1:0]    b_use;

    stream_buffer_flushable #(.DATA_WIDTH(DW), .DEPTH(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
        .inp_data_i(a_d), .inp_valid_i(a_v), .inp_ready_o(a_rdy),
        .oup_data_o(a_od), .oup_valid_o(a_ov), .oup_ready_i(a_r),
        .usage_o(a_use), .full_o(a_full), .empty_o(a_empty)
    );

    stream_buffer_flushable #(.DATA_WIDTH(DW), .DEPTH(3)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
        .inp_data_i(b_d), .inp_valid_i(b_v), .inp_ready_o(b_rdy),
        .oup_data_o(b_od), .oup_valid_o(b_ov), .oup_ready_i(b_r),
        .usage_o(b_use), .full_o(b_full), .empty_o(b_empty)
    );

    int checks = 0;
    int passed = 0;
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];

    typedef struct {
        logic          f, v;
        logic [DW-1:0] d;
        logic          r;
        logic          erdy, evld;
        logic [DW-1:0] edat;
        int            euse;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic drive_a(input logic f, input logic v, input logic [DW-1:0] d, input logic r);
        a_flush = f; a_v = v; a_d = d; a_r = r;
    endtask

    // Queue model: outputs derived from occupancy, update applied once per cycle.
    task automatic model_a();
        bit er, ev;
        er = (qa.size() < 4) && !a_flush;
        ev = (qa.size() > 0) && !a_flush;
        chk("a_ready", int'(a_rdy), int'(er));
        chk("a_valid", int'(a_ov), int'(ev));
        chk("a_usage", int'(a_use), qa.size());
        chk("a_full", int'(a_full), int'(qa.size() == 4));
        chk("a_empty", int'(a_empty), int'(qa.size() == 0));
        if (ev) chk("a_data", int'(a_od), int'(qa[0]));
        if (a_flush) qa.delete();
        else begin
            if (ev && a_r) void'(qa.pop_front());
            if (er && a_v) qa.push_back(a_d);
        end
    endtask

    task automatic model_b();
        bit er, ev;
        er = (qb.size() < 3) && !b_flush;
        ev = (qb.size() > 0) && !b_flush;
        chk("b_ready", int'(b_rdy), int'(er));
        chk("b_valid", int'(b_ov), int'(ev));
        chk("b_usage", int'(b_use), qb.size());
        chk("b_full", int'(b_full), int'(qb.size() == 3));
        chk("b_empty", int'(b_empty), int'(qb.size() == 0));
        if (ev) chk("b_data", int'(b_od), int'(qb[0]));
        if (b_flush) qb.delete();
        else begin
            if (ev && b_r) void'(qb.pop_front());
            if (er && b_v) qb.push_back(b_d);
        end
    endtask

    initial begin
        int nin, nout;
        //            f  v  d      r  rdy vld dat    use
        tbl[0]  = '{1'b0,1'b1,8'h01,1'b0, 1'b1,1'b0,8'h00, 0};
        tbl[1]  = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h01, 1};
        tbl[2]  = '{1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00, 0};
        tbl[3]  = '{1'b0,1'b1,8'h0A,1'b0, 1'b1,1'b0,8'h00, 0};
        tbl[4]  = '{1'b0,1'b1,8'h0B,1'b0, 1'b1,1'b1,8'h0A, 1};
        tbl[5]  = '{1'b0,1'b1,8'h0C,1'b0, 1'b1,1'b1,8'h0A, 2};
        tbl[6]  = '{1'b0,1'b1,8'h0D,1'b0, 1'b1,1'b1,8'h0A, 3};
        tbl[7]  = '{1'b0,1'b1,8'h0F,1'b0, 1'b0,1'b1,8'h0A, 4};
        tbl[8]  = '{1'b0,1'b1,8'h0E,1'b1, 1'b0,1'b1,8'h0A, 4};
        tbl[9]  = '{1'b0,1'b1,8'h0E,1'b1, 1'b1,1'b1,8'h0B, 3};
        tbl[10] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h0C, 3};
        tbl[11] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h0D, 2};
        tbl[12] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h0E, 1};
        tbl[13] = '{1'b0,1'b1,8'h01,1'b0, 1'b1,1'b0,8'h00, 0};
        tbl[14] = '{1'b0,1'b1,8'h02,1'b0, 1'b1,1'b1,8'h01, 1};
        tbl[15] = '{1'b0,1'b1,8'h03,1'b0, 1'b1,1'b1,8'h01, 2};
        tbl[16] = '{1'b1,1'b1,8'h04,1'b1, 1'b0,1'b0,8'h00, 3};
        tbl[17] = '{1'b0,1'b1,8'h05,1'b0, 1'b1,1'b0,8'h00, 0};
        tbl[18] = '{1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h05, 1};
        tbl[19] = '{1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00, 0};

        rst_n = 1'b0;
        drive_a(1'b0, 1'b0, '0, 1'b0);
        b_flush = 1'b0; b_v = 1'b0; b_d = '0; b_r = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_ready", int'(a_rdy), 1);
        chk("rst_a_valid", int'(a_ov), 0);
        chk("rst_a_usage", int'(a_use), 0);
        chk("rst_a_empty", int'(a_empty), 1);
        chk("rst_a_full", int'(a_full), 0);
        chk("rst_b_valid", int'(b_ov), 0);
        chk("rst_b_empty", int'(b_empty), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: single beat, fill to full, flush mid-operation.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive_a(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].r);
            #1;
            chk($sformatf("vec%0d_ready", i), int'(a_rdy), int'(tbl[i].erdy));
            chk($sformatf("vec%0d_valid", i), int'(a_ov), int'(tbl[i].evld));
            chk($sformatf("vec%0d_usage", i), int'(a_use), tbl[i].euse);
            chk($sformatf("vec%0d_full", i), int'(a_full), int'(tbl[i].euse == 4));
            chk($sformatf("vec%0d_empty", i), int'(a_empty), int'(tbl[i].euse == 0));
            if (tbl[i].evld) chk($sformatf("vec%0d_data", i), int'(a_od), int'(tbl[i].edat));
        end

        // Sustained simultaneous push/pop at occupancy 2.
        @(negedge clk); drive_a(1'b0, 1'b1, 8'h20, 1'b0);
        @(negedge clk); drive_a(1'b0, 1'b1, 8'h21, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_a(1'b0, 1'b1, 8'(8'h22 + i), 1'b1);
            #1;
            chk("stream_usage", int'(a_use), 2);
            chk("stream_valid", int'(a_ov), 1);
            chk("stream_data", int'(a_od), 8'h20 + i);
        end
        repeat (2) begin @(negedge clk); drive_a(1'b0, 1'b0, '0, 1'b1); end
        @(negedge clk); drive_a(1'b0, 1'b0, '0, 1'b0);
        #1 chk("stream_drained", int'(a_empty), 1);

        // DEPTH=3 wrap-around: 7 beats, irregular push/pop interleave.
        nin = 0; nout = 0;
        for (int c = 0; c < 200 && nout < 7; c++) begin
            @(negedge clk);
            b_v = (nin < 7) && ($urandom_range(0, 3) != 0);
            b_d = 8'(nin);
            b_r = ($urandom_range(0, 1) == 1);
            #1;
            if (b_ov && b_r) begin
                chk("wrap_data", int'(b_od), nout);
                nout++;
            end
            if (b_v && b_rdy) nin++;
        end
        chk("wrap_count", nout, 7);
        @(negedge clk); b_v = 1'b0; b_r = 1'b0;
        #1 chk("wrap_empty", int'(b_empty), 1);

        // Asynchronous reset while full.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive_a(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        end
        @(negedge clk); drive_a(1'b0, 1'b0, '0, 1'b0);
        #1 chk("pre_rst_full", int'(a_full), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(a_ov), 0);
        chk("arst_usage", int'(a_use), 0);
        chk("arst_empty", int'(a_empty), 1);
        chk("arst_full", int'(a_full), 0);
        chk("arst_ready", int'(a_rdy), 1);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); drive_a(1'b0, 1'b1, 8'h77, 1'b0);
        @(negedge clk); drive_a(1'b0, 1'b0, '0, 1'b1);
        #1;
        chk("post_rst_valid", int'(a_ov), 1);
        chk("post_rst_data", int'(a_od), 8'h77);
        chk("post_rst_usage", int'(a_use), 1);

        // Randomized traffic with occasional flushes against the queue model.
        qa.delete(); qb.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            drive_a($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                    8'($urandom), $urandom_range(0, 9) < 6);
            b_flush = ($urandom_range(0, 19) == 0);
            b_v = ($urandom_range(0, 9) < 6);
            b_d = 8'($urandom);
            b_r = ($urandom_range(0, 9) < 7);
            #1;
            model_a();
            model_b();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
